master_port_router: RTL and testbench
=====================================

Name: master_port_router

Overview:
- Per-master front end of the interconnect; one instance per master port. Pairs with the per-slave output arbiters.
- Captures a master transaction and decodes its address to one slave index.
- Drives that slave's arbiter request line and a one-cycle new-transaction flag, then waits for grant and slave ready.
- Returns read data or an error to the master. Unmapped addresses and timeouts complete locally with an error.

Parameters:
NUM_OUTPUTS, 5, number of slave ports
ADDR_W, 32, address width
DATA_W, 32, data width
SLAVE_BASE, {0x4000_0000,0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, flattened NUM_OUTPUTS*ADDR_W base addresses (slave 0 in LSBs)
SLAVE_MASK, all 0xF000_0000, flattened NUM_OUTPUTS*ADDR_W compare masks
TIMEOUT_CYCLES, 255, cycles in REQ before abort; 0 disables
ERR_DATA, 0xDEAD_BEEF, read data returned on error

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  asynchronous active-low reset
i_M_Valid  in  1  master request; held with addr/data until o_M_Ready
i_M_Write  in  1  1=write
i_M_Addr  in  ADDR_W  address
i_M_WData  in  DATA_W  write data
i_M_WStrb  in  DATA_W/8  byte strobes
o_M_Ready  out  1  one-cycle completion pulse
o_M_Err  out  1  error qualifier, valid with o_M_Ready
o_M_RData  out  DATA_W  read data, valid with o_M_Ready
o_S_Req  out  NUM_OUTPUTS  one-hot request to slave arbiters
o_S_NewTransaction  out  1  high on first request cycle only
o_S_Write, o_S_Addr, o_S_WData, o_S_WStrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered copies for slave muxes
i_S_Grant  in  NUM_OUTPUTS  bit k=1 when slave k arbiter selects this master
i_S_Ready  in  NUM_OUTPUTS  per-slave done
i_S_RData  in  NUM_OUTPUTS*DATA_W  per-slave read data, flattened

Behaviour:
- Reset (async, immediate): state IDLE, o_S_Req=0, o_S_NewTransaction=0, o_M_Ready=0, o_M_Err=0, o_M_RData=0, captured regs=0, timeout counter=0.
- IDLE: on i_M_Valid, capture addr/write/wdata/wstrb. Decode: hit on slave k when (addr & MASK_k)==BASE_k; lowest k wins on multiple hits. Hit -> REQ with r_Idx=k. Miss -> ERR.
- REQ: o_S_Req[r_Idx]=1. o_S_NewTransaction=1 in the first REQ cycle only. Counter increments each REQ cycle.
  - i_S_Grant[r_Idx] && i_S_Ready[r_Idx] in the same cycle: latch i_S_RData slice r_Idx, go RESP. Req is still high in that cycle.
  - Ready without grant: ignored.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without completion: go ERR. Completion in that same cycle wins over timeout.
- RESP: o_M_Ready=1, o_M_Err=0, o_S_Req=0; next IDLE.
- ERR: o_M_Ready=1, o_M_Err=1, o_M_RData=ERR_DATA, o_S_Req=0; next IDLE.
- Back-to-back: a new transaction can be captured in the IDLE cycle immediately after RESP/ERR.
- Minimum latency: valid at cycle 0 -> o_M_Ready at cycle 2 (grant+ready in first REQ cycle). Decode miss -> o_M_Ready at cycle 1.
- i_M_Valid dropping mid-transaction is a protocol violation; the transaction still completes normally.
- Write completion returns o_M_RData = latched slave data (don't-care).
- Reset mid-REQ: o_S_Req drops asynchronously; no completion pulse.
- State encoding: 2-bit IDLE=0, REQ=1, RESP=2, ERR=3.

Decomposition:
- Shared interconnect package: state encoding, ERR_DATA default, NUM_OUTPUTS default, clog2 index width.
- Sub-module addr_region_decode (combinational):
  - Inputs: address, SLAVE_BASE/SLAVE_MASK.
  - Outputs: hit flag and lowest-index match.
  - Reused by other master ports.

Test Plan:
- Read 0x1000_0010, i_S_Grant[1] and i_S_Ready[1] high in first REQ cycle, RData slice1=0x1234_5678 -> o_S_Req=5'b00010 for 1 cycle, NewTransaction=1 same cycle; o_M_Ready at cycle 2, RData=0x1234_5678, Err=0.
- Write 0x2000_0000, grant at REQ cycle 3, ready at REQ cycle 5 -> Req[2] held 5 cycles, NewTransaction only cycle 1; o_S_WData/WStrb stable throughout; Ready at cycle 6.
- Read 0x8000_0000 (no match) -> no o_S_Req; o_M_Ready=1, Err=1, RData=0xDEAD_BEEF at cycle 1.
- TIMEOUT_CYCLES=4, grant never arrives -> Req[0] high 4 cycles, then ERR pulse with RData 0xDEAD_BEEF; back in IDLE.
- Assert i_Rst_n=0 mid-REQ -> o_S_Req=0 without waiting for a clock edge; after release, a new read completes normally with NewTransaction reasserted.
- Two back-to-back reads to slaves 3 then 4 -> second capture in the cycle after the first Ready; NewTransaction pulses once per transaction.

Source files
------------

// File: rtl/master_port_router_pkg.sv
// Shared interconnect definitions: FSM encoding, default sizes, index width helper.
package master_port_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_OUTPUTS = 5;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

  // Width of a slave index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/master_port_router_if.sv
// Master-side bus and slave-arbiter side signals of one master port.
interface master_port_router_if #(
  parameter int unsigned NUM_OUTPUTS = 5,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
);
  logic                          i_M_Valid;
  logic                          i_M_Write;
  logic [ADDR_W-1:0]             i_M_Addr;
  logic [DATA_W-1:0]             i_M_WData;
  logic [DATA_W/8-1:0]           i_M_WStrb;
  logic                          o_M_Ready;
  logic                          o_M_Err;
  logic [DATA_W-1:0]             o_M_RData;
  logic [NUM_OUTPUTS-1:0]        o_S_Req;
  logic                          o_S_NewTransaction;
  logic                          o_S_Write;
  logic [ADDR_W-1:0]             o_S_Addr;
  logic [DATA_W-1:0]             o_S_WData;
  logic [DATA_W/8-1:0]           o_S_WStrb;
  logic [NUM_OUTPUTS-1:0]        i_S_Grant;
  logic [NUM_OUTPUTS-1:0]        i_S_Ready;
  logic [NUM_OUTPUTS*DATA_W-1:0] i_S_RData;

  // Router view: slave to the master, requester towards the slave arbiters.
  modport slave (
    input  i_M_Valid, i_M_Write, i_M_Addr, i_M_WData, i_M_WStrb,
    output o_M_Ready, o_M_Err, o_M_RData,
    output o_S_Req, o_S_NewTransaction, o_S_Write, o_S_Addr, o_S_WData, o_S_WStrb,
    input  i_S_Grant, i_S_Ready, i_S_RData
  );

  // Environment view: the master plus the slave arbiters.
  modport master (
    output i_M_Valid, i_M_Write, i_M_Addr, i_M_WData, i_M_WStrb,
    input  o_M_Ready, o_M_Err, o_M_RData,
    input  o_S_Req, o_S_NewTransaction, o_S_Write, o_S_Addr, o_S_WData, o_S_WStrb,
    output i_S_Grant, i_S_Ready, i_S_RData
  );
endinterface

// File: rtl/master_port_router_addr_region_decode.sv
// Address-to-slave decoder; lowest matching region wins. Shared by all master ports.
module master_port_router_addr_region_decode
  import master_port_router_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned IDX_W       = idx_width(NUM_OUTPUTS)
) (
  input  logic [ADDR_W-1:0]             i_Addr,
  input  logic [NUM_OUTPUTS*ADDR_W-1:0] i_Base,
  input  logic [NUM_OUTPUTS*ADDR_W-1:0] i_Mask,
  output logic                          o_Hit_c,
  output logic [IDX_W-1:0]              o_Idx_c
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    o_Hit_c = 1'b0;
    o_Idx_c = '0;
    for (int k = int'(NUM_OUTPUTS) - 1; k >= 0; k--) begin
      if ((i_Addr & i_Mask[k*ADDR_W +: ADDR_W]) == i_Base[k*ADDR_W +: ADDR_W]) begin
        o_Hit_c = 1'b1;
        o_Idx_c = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/master_port_router.sv
// Per-master front end: captures a transaction, routes it to one slave arbiter,
// and returns read data or an error (unmapped address or timeout).
module master_port_router
  import master_port_router_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS    = DEF_NUM_OUTPUTS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter logic [NUM_OUTPUTS*ADDR_W-1:0] SLAVE_BASE = {32'h4000_0000, 32'h3000_0000,
                                                         32'h2000_0000, 32'h1000_0000,
                                                         32'h0000_0000},
  parameter logic [NUM_OUTPUTS*ADDR_W-1:0] SLAVE_MASK = {5{32'hF000_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  master_port_router_if.slave bus
);

  localparam int unsigned IDX_W     = idx_width(NUM_OUTPUTS);
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  state_t                 r_State;
  logic [IDX_W-1:0]       r_Idx;
  logic                   r_Write;
  logic [ADDR_W-1:0]      r_Addr;
  logic [DATA_W-1:0]      r_WData;
  logic [DATA_W/8-1:0]    r_WStrb;
  logic [NUM_OUTPUTS-1:0] r_Req;
  logic                   r_New;
  logic                   r_Ready;
  logic                   r_Err;
  logic [DATA_W-1:0]      r_RData;
  logic [CNT_W-1:0]       r_Cnt;

  logic                   w_Hit;
  logic [IDX_W-1:0]       w_DecIdx;
  logic                   w_Gnt;
  logic                   w_Rdy;
  logic [DATA_W-1:0]      w_SliceRData;

  master_port_router_addr_region_decode #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) u_decode (
    .i_Addr  (bus.i_M_Addr),
    .i_Base  (SLAVE_BASE),
    .i_Mask  (SLAVE_MASK),
    .o_Hit_c (w_Hit),
    .o_Idx_c (w_DecIdx)
  );

  assign w_Gnt = bus.i_S_Grant[r_Idx];
  assign w_Rdy = bus.i_S_Ready[r_Idx];

  // Select the read-data slice of the slave currently being addressed.
  always_comb begin
    w_SliceRData = '0;
    for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
      if (r_Idx == IDX_W'(k)) w_SliceRData = bus.i_S_RData[k*DATA_W +: DATA_W];
    end
  end

  // Transaction FSM with registered outputs; completion beats timeout in the same cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State <= ST_IDLE;
      r_Idx   <= '0;
      r_Write <= 1'b0;
      r_Addr  <= '0;
      r_WData <= '0;
      r_WStrb <= '0;
      r_Req   <= '0;
      r_New   <= 1'b0;
      r_Ready <= 1'b0;
      r_Err   <= 1'b0;
      r_RData <= '0;
      r_Cnt   <= '0;
    end else begin
      r_New   <= 1'b0;
      r_Ready <= 1'b0;
      r_Err   <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (bus.i_M_Valid) begin
            r_Write <= bus.i_M_Write;
            r_Addr  <= bus.i_M_Addr;
            r_WData <= bus.i_M_WData;
            r_WStrb <= bus.i_M_WStrb;
            r_Cnt   <= '0;
            if (w_Hit) begin
              r_State <= ST_REQ;
              r_Idx   <= w_DecIdx;
              r_Req   <= NUM_OUTPUTS'(1) << w_DecIdx;
              r_New   <= 1'b1;
            end else begin
              r_State <= ST_ERR;
              r_Ready <= 1'b1;
              r_Err   <= 1'b1;
              r_RData <= ERR_DATA;
            end
          end
        end
        ST_REQ: begin
          if (w_Gnt && w_Rdy) begin
            r_State <= ST_RESP;
            r_Req   <= '0;
            r_Ready <= 1'b1;
            r_RData <= w_SliceRData;
          end else if ((TIMEOUT_CYCLES != 0) && (r_Cnt == TO_LAST)) begin
            r_State <= ST_ERR;
            r_Req   <= '0;
            r_Ready <= 1'b1;
            r_Err   <= 1'b1;
            r_RData <= ERR_DATA;
          end else begin
            r_Cnt <= r_Cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_State <= ST_IDLE;
        ST_ERR:  r_State <= ST_IDLE;
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_M_Ready          = r_Ready;
  assign bus.o_M_Err            = r_Err;
  assign bus.o_M_RData          = r_RData;
  assign bus.o_S_Req            = r_Req;
  assign bus.o_S_NewTransaction = r_New;
  assign bus.o_S_Write          = r_Write;
  assign bus.o_S_Addr           = r_Addr;
  assign bus.o_S_WData          = r_WData;
  assign bus.o_S_WStrb          = r_WStrb;

endmodule

// File: tb/tb_master_port_router.sv
// Scoreboard bench for master_port_router: default-timeout instance A, 4-cycle-timeout instance B.
module tb_master_port_router;

  localparam int unsigned NO = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  master_port_router_if #(.NUM_OUTPUTS(NO), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  master_port_router_if #(.NUM_OUTPUTS(NO), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  master_port_router #(.TIMEOUT_CYCLES(255)) u_a (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_a));
  master_port_router #(.TIMEOUT_CYCLES(4))   u_b (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Completion monitor for instance A.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus_a.o_M_Ready === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_err", 32'(bus_a.o_M_Err), 32'(e.err));
        if (e.chk_data) chk("a_rdata", bus_a.o_M_RData, e.rdata);
        chk("a_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Completion monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus_b.o_M_Ready === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_err", 32'(bus_b.o_M_Err), 32'(e.err));
        if (e.chk_data) chk("b_rdata", bus_b.o_M_RData, e.rdata);
        chk("b_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic clear_a();
    bus_a.i_M_Valid = 1'b0;
    bus_a.i_M_Write = 1'b0;
    bus_a.i_M_Addr  = '0;
    bus_a.i_M_WData = '0;
    bus_a.i_M_WStrb = '0;
    bus_a.i_S_Grant = '0;
    bus_a.i_S_Ready = '0;
    bus_a.i_S_RData = '0;
  endtask

  task automatic clear_b();
    bus_b.i_M_Valid = 1'b0;
    bus_b.i_M_Write = 1'b0;
    bus_b.i_M_Addr  = '0;
    bus_b.i_M_WData = '0;
    bus_b.i_M_WStrb = '0;
    bus_b.i_S_Grant = '0;
    bus_b.i_S_Ready = '0;
    bus_b.i_S_RData = '0;
  endtask

  // One transaction on A, called just after a rising edge. slv<0 means unmapped.
  // Grant is high from REQ cycle gnt_at onward, ready from rdy_at onward.
  task automatic run_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input int slv, input int gnt_at,
                       input int rdy_at, input logic [31:0] sdata);
    exp_t             e;
    int               done_r;
    logic [NO*DW-1:0] rd;
    logic [NO-1:0]    oh;
    rd = '0;
    oh = '0;
    if (slv >= 0) begin
      rd[slv*DW +: DW] = sdata;
      oh[slv] = 1'b1;
    end
    done_r     = (slv < 0) ? 0 : ((gnt_at > rdy_at) ? gnt_at : rdy_at);
    e.err      = (slv < 0);
    e.rdata    = (slv < 0) ? 32'hDEAD_BEEF : sdata;
    e.chk_data = (slv < 0) || !wr;
    e.cyc      = cyc + done_r + 1;
    qa.push_back(e);
    bus_a.i_M_Valid = 1'b1;
    bus_a.i_M_Write = wr;
    bus_a.i_M_Addr  = addr;
    bus_a.i_M_WData = wd;
    bus_a.i_M_WStrb = st;
    bus_a.i_S_RData = rd;
    for (int r = 1; r <= done_r + 1; r++) begin
      @(posedge clk);
      #1;
      bus_a.i_S_Grant = (r >= gnt_at) ? oh : '0;
      bus_a.i_S_Ready = (r >= rdy_at) ? oh : '0;
      @(negedge clk);
      if (r <= done_r) begin
        chk("req_onehot", 32'(bus_a.o_S_Req), 32'(oh));
        chk("new_txn", 32'(bus_a.o_S_NewTransaction), 32'(r == 1));
        chk("s_addr", bus_a.o_S_Addr, addr);
        chk("s_write", 32'(bus_a.o_S_Write), 32'(wr));
        chk("s_wdata", bus_a.o_S_WData, wd);
        chk("s_wstrb", 32'(bus_a.o_S_WStrb), 32'(st));
      end else begin
        chk("req_low_at_done", 32'(bus_a.o_S_Req), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    clear_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clear_a();
    clear_b();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", 32'(bus_a.o_S_Req), 32'd0);
    chk("rst_new", 32'(bus_a.o_S_NewTransaction), 32'd0);
    chk("rst_ready", 32'(bus_a.o_M_Ready), 32'd0);
    chk("rst_err", 32'(bus_a.o_M_Err), 32'd0);
    chk("rst_rdata", bus_a.o_M_RData, 32'd0);
    chk("rst_addr", bus_a.o_S_Addr, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Minimum-latency read to slave 1.
    run_a(1'b0, 32'h1000_0010, 32'h0, 4'h0, 1, 1, 1, 32'h1234_5678);
    // Write to slave 2, grant at REQ cycle 3, ready at 5.
    run_a(1'b1, 32'h2000_0000, 32'hA5A5_0F0F, 4'b0110, 2, 3, 5, 32'h0BAD_0BAD);
    // Unmapped address.
    run_a(1'b0, 32'h8000_0000, 32'h0, 4'h0, -1, 0, 0, 32'h0);
    // Ready without grant is ignored until grant shows up.
    run_a(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 3, 1, 32'h5555_AAAA);
    // Back-to-back reads to slaves 3 and 4, top-of-region address on the second.
    run_a(1'b0, 32'h3000_0004, 32'h0, 4'h0, 3, 1, 1, 32'h3333_3333);
    run_a(1'b0, 32'h4FFF_FFFC, 32'h0, 4'h0, 4, 2, 1, 32'h4444_4444);

    // Reset in the middle of REQ drops the request without a clock edge.
    bus_a.i_M_Valid = 1'b1;
    bus_a.i_M_Addr  = 32'h1000_0020;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus_a.o_S_Req), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_a.o_S_Req), 32'd0);
    chk("async_rst_new", 32'(bus_a.o_S_NewTransaction), 32'd0);
    chk("async_rst_ready", 32'(bus_a.o_M_Ready), 32'd0);
    clear_a();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_a(1'b0, 32'h1000_0030, 32'h0, 4'h0, 1, 1, 1, 32'h0FED_CBA9);

    // Instance B: grant never comes, ready alone is ignored, timeout after 4 REQ cycles.
    begin
      exp_t e;
      e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.chk_data = 1'b1; e.cyc = cyc + 5;
      qb.push_back(e);
      bus_b.i_M_Valid = 1'b1;
      bus_b.i_M_Addr  = 32'h0000_0040;
      bus_b.i_S_Ready = 5'b00001;
      for (int r = 1; r <= 5; r++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        if (r <= 4) begin
          chk("b_to_req", 32'(bus_b.o_S_Req), 32'h1);
          chk("b_to_new", 32'(bus_b.o_S_NewTransaction), 32'(r == 1));
        end else begin
          chk("b_to_req_low", 32'(bus_b.o_S_Req), 32'd0);
        end
      end
      @(posedge clk);
      #1;
      clear_b();

      // Completion in the final allowed REQ cycle beats the timeout.
      e.err = 1'b0; e.rdata = 32'hCAFE_F00D; e.chk_data = 1'b1; e.cyc = cyc + 5;
      qb.push_back(e);
      bus_b.i_M_Valid = 1'b1;
      bus_b.i_M_Addr  = 32'h0000_0080;
      bus_b.i_S_RData = {128'h0, 32'hCAFE_F00D};
      for (int r = 1; r <= 5; r++) begin
        @(posedge clk);
        #1;
        bus_b.i_S_Grant = (r == 4) ? 5'b00001 : 5'b00000;
        bus_b.i_S_Ready = (r == 4) ? 5'b00001 : 5'b00000;
        @(negedge clk);
        if (r <= 4) chk("b_edge_req", 32'(bus_b.o_S_Req), 32'h1);
        else        chk("b_edge_req_low", 32'(bus_b.o_S_Req), 32'd0);
      end
      @(posedge clk);
      #1;
      clear_b();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("a_pending", 32'(qa.size()), 32'd0);
    chk("b_pending", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
